// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle shared by the fetch port, the load/store port and the DRAM port.
// The arbiter takes the slave view; the surrounding system (or bench) takes the master view.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 64
);
   logic              fetch_req_valid;
   logic [ADDR_W-1:0] fetch_req_addr;
   logic              fetch_req_ready;
   logic              fetch_resp_valid;
   logic [DATA_W-1:0] fetch_resp_data;

   logic              data_req_valid;
   logic              data_req_write;
   logic [ADDR_W-1:0] data_req_addr;
   logic [DATA_W-1:0] data_req_wdata;
   logic              data_req_ready;
   logic              data_resp_valid;
   logic [DATA_W-1:0] data_resp_data;

   logic              dram_req_valid;
   logic              dram_req_write;
   logic [ADDR_W-1:0] dram_req_addr;
   logic [DATA_W-1:0] dram_req_wdata;
   logic              dram_req_ready;
   logic              dram_resp_valid;
   logic [DATA_W-1:0] dram_resp_data;

   logic              owner;
   logic              busy;
   logic              timeout_err;

   modport slave (
      input  fetch_req_valid, fetch_req_addr,
      input  data_req_valid, data_req_write, data_req_addr, data_req_wdata,
      input  dram_req_ready, dram_resp_valid, dram_resp_data,
      output fetch_req_ready, fetch_resp_valid, fetch_resp_data,
      output data_req_ready, data_resp_valid, data_resp_data,
      output dram_req_valid, dram_req_write, dram_req_addr, dram_req_wdata,
      output owner, busy, timeout_err
   );

   modport master (
      output fetch_req_valid, fetch_req_addr,
      output data_req_valid, data_req_write, data_req_addr, data_req_wdata,
      output dram_req_ready, dram_resp_valid, dram_resp_data,
      input  fetch_req_ready, fetch_resp_valid, fetch_resp_data,
      input  data_req_ready, data_resp_valid, data_resp_data,
      input  dram_req_valid, dram_req_write, dram_req_addr, dram_req_wdata,
      input  owner, busy, timeout_err
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-port DRAM arbiter between instruction fetch and load/store, one transaction in flight.
// Data normally wins ties; a starvation counter forces a fetch grant, and a watchdog aborts lost responses.
module mem_bus_arbiter #(
   parameter int ADDR_W         = 21,
   parameter int DATA_W         = 64,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   mem_bus_arbiter_if.slave bus
);
   localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
   localparam logic [15:0]     TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              grant_fetch;
   logic              grant_data;
   logic              resp_done;
   logic              tmo_hit;
   logic [DATA_W-1:0] resp_word;

   logic              owner_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [SC_W-1:0]   starve_cnt;
   logic [15:0]       tmo_cnt;
   logic              timeout_err_q;
   logic              fetch_req_ready_q;
   logic              data_req_ready_q;
   logic              fetch_resp_valid_q;
   logic              data_resp_valid_q;
   logic [DATA_W-1:0] fetch_resp_data_q;
   logic [DATA_W-1:0] data_resp_data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      resp_done   = 1'b0;
      tmo_hit     = 1'b0;
      resp_word   = '0;
      unique case (state)
         IDLE: begin
            // Data wins a tie unless fetch has already been passed over STARVE_LIMIT times.
            if (bus.data_req_valid && !(bus.fetch_req_valid && starve_cnt == STARVE_MAX)) begin
               grant_data = 1'b1;
               state_nxt  = ISSUE;
            end else if (bus.fetch_req_valid) begin
               grant_fetch = 1'b1;
               state_nxt   = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.dram_req_ready) state_nxt = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (bus.dram_resp_valid) begin
               resp_done = 1'b1;
               resp_word = write_q ? '0 : bus.dram_resp_data;
               state_nxt = RESPOND;
            end else if (tmo_cnt == TMO_LAST) begin
               resp_done = 1'b1;
               tmo_hit   = 1'b1;
               resp_word = '1;
               state_nxt = RESPOND;
            end
         end
         RESPOND: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q            <= 1'b0;
         write_q            <= 1'b0;
         addr_q             <= '0;
         wdata_q            <= '0;
         starve_cnt         <= '0;
         tmo_cnt            <= '0;
         timeout_err_q      <= 1'b0;
         fetch_req_ready_q  <= 1'b0;
         data_req_ready_q   <= 1'b0;
         fetch_resp_valid_q <= 1'b0;
         data_resp_valid_q  <= 1'b0;
         fetch_resp_data_q  <= '0;
         data_resp_data_q   <= '0;
      end else begin
         fetch_req_ready_q  <= grant_fetch;
         data_req_ready_q   <= grant_data;
         fetch_resp_valid_q <= resp_done && !owner_q;
         data_resp_valid_q  <= resp_done && owner_q;

         if (grant_fetch) begin
            owner_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= bus.fetch_req_addr;
            wdata_q    <= '0;
            starve_cnt <= '0;
         end
         if (grant_data) begin
            owner_q <= 1'b1;
            write_q <= bus.data_req_write;
            addr_q  <= bus.data_req_addr;
            wdata_q <= bus.data_req_wdata;
            if (bus.fetch_req_valid && starve_cnt != STARVE_MAX)
               starve_cnt <= starve_cnt + SC_W'(1);
         end

         // Watchdog restarts every time a request is sitting at the DRAM port.
         if (state == ISSUE)          tmo_cnt <= '0;
         else if (state == WAIT_RESP) tmo_cnt <= tmo_cnt + 16'd1;

         if (resp_done && !owner_q) fetch_resp_data_q <= resp_word;
         if (resp_done && owner_q)  data_resp_data_q  <= resp_word;
         if (tmo_hit)               timeout_err_q     <= 1'b1;
      end
   end

   assign bus.fetch_req_ready  = fetch_req_ready_q;
   assign bus.data_req_ready   = data_req_ready_q;
   assign bus.fetch_resp_valid = fetch_resp_valid_q;
   assign bus.data_resp_valid  = data_resp_valid_q;
   assign bus.fetch_resp_data  = fetch_resp_data_q;
   assign bus.data_resp_data   = data_resp_data_q;
   assign bus.dram_req_valid   = (state == ISSUE);
   assign bus.dram_req_write   = write_q;
   assign bus.dram_req_addr    = addr_q;
   assign bus.dram_req_wdata   = wdata_q;
   assign bus.owner            = owner_q;
   assign bus.busy             = (state != IDLE);
   assign bus.timeout_err      = timeout_err_q;
endmodule
